// File: rtl/muntjac_pkg.sv
// Shared Muntjac frontend types: reasons attached to a fetch redirect.
package muntjac_pkg;

  // Why the instruction fetcher is being steered to a new PC.
  typedef enum logic [2:0] {
    IF_PREFETCH     = 3'd0,
    IF_TRAP         = 3'd1,
    IF_MISPREDICT   = 3'd2,
    IF_FENCE_I      = 3'd3,
    IF_SATP_CHANGED = 3'd4
  } if_reason_e;

endpackage

// File: rtl/muntjac_redirect_ctrl_if.sv
// Redirect request/response bundle between the redirect sources, the icache
// flush port and the instruction fetcher. "slave" is the controller side.
interface muntjac_redirect_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  import muntjac_pkg::*;

  logic            trap_valid_i;
  logic            trap_ready_o;
  logic [XLEN-1:0] trap_pc_i;

  logic            mispred_valid_i;
  logic            mispred_ready_o;
  logic [XLEN-1:0] mispred_pc_i;

  logic            sys_valid_i;
  logic            sys_ready_o;
  logic [XLEN-1:0] sys_pc_i;
  if_reason_e      sys_reason_i;
  logic            sys_flush_i;
  logic            sys_done_o;

  logic            icache_flush_req_o;
  logic            icache_flush_ack_i;

  logic            redirect_valid_o;
  if_reason_e      redirect_reason_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport slave (
    input  trap_valid_i, trap_pc_i,
    output trap_ready_o,
    input  mispred_valid_i, mispred_pc_i,
    output mispred_ready_o,
    input  sys_valid_i, sys_pc_i, sys_reason_i, sys_flush_i,
    output sys_ready_o, sys_done_o,
    input  icache_flush_ack_i,
    output icache_flush_req_o,
    output redirect_valid_o, redirect_reason_o, redirect_pc_o
  );

  modport master (
    output trap_valid_i, trap_pc_i,
    input  trap_ready_o,
    output mispred_valid_i, mispred_pc_i,
    input  mispred_ready_o,
    output sys_valid_i, sys_pc_i, sys_reason_i, sys_flush_i,
    input  sys_ready_o, sys_done_o,
    output icache_flush_ack_i,
    input  icache_flush_req_o,
    input  redirect_valid_o, redirect_reason_o, redirect_pc_o
  );

endinterface

// File: rtl/muntjac_redirect_ctrl.sv
// Arbitrates trap, mispredict and system redirect requests and issues a
// single-cycle redirect to the fetcher, optionally preceded by an icache
// flush handshake for system requests.
module muntjac_redirect_ctrl
  import muntjac_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  muntjac_redirect_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // Fetch PCs are halfword aligned; bit 0 is always cleared.
  localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  state_e          state_q, state_d;
  logic            redirect_valid_q, redirect_valid_d;
  if_reason_e      redirect_reason_q, redirect_reason_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            sys_done_q, sys_done_d;
  logic            flush_req_q, flush_req_d;
  // System request parked while the icache flush is in progress.
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  if_reason_e      pend_reason_q, pend_reason_d;

  logic idle_s;
  logic trap_acc_s, mispred_acc_s, sys_acc_s;

  // Only the highest-priority valid source sees ready; nothing is accepted
  // while reset is asserted.
  assign idle_s            = (state_q == ST_IDLE) && !rst_i;
  assign bus.trap_ready_o    = idle_s;
  assign bus.mispred_ready_o = idle_s && !bus.trap_valid_i;
  assign bus.sys_ready_o     = idle_s && !bus.trap_valid_i && !bus.mispred_valid_i;

  assign trap_acc_s    = bus.trap_valid_i    && bus.trap_ready_o;
  assign mispred_acc_s = bus.mispred_valid_i && bus.mispred_ready_o;
  assign sys_acc_s     = bus.sys_valid_i     && bus.sys_ready_o;

  assign bus.redirect_valid_o   = redirect_valid_q;
  assign bus.redirect_reason_o  = redirect_reason_q;
  assign bus.redirect_pc_o      = redirect_pc_q;
  assign bus.sys_done_o         = sys_done_q;
  assign bus.icache_flush_req_o = flush_req_q;

  // Next state and next registered outputs; the redirect PC/reason only
  // change when a redirect is actually issued.
  always_comb begin
    state_d           = state_q;
    redirect_valid_d  = 1'b0;
    redirect_reason_d = redirect_reason_q;
    redirect_pc_d     = redirect_pc_q;
    sys_done_d        = 1'b0;
    flush_req_d       = 1'b0;
    pend_pc_d         = pend_pc_q;
    pend_reason_d     = pend_reason_q;

    case (state_q)
      ST_IDLE: begin
        if (trap_acc_s) begin
          state_d           = ST_ISSUE;
          redirect_valid_d  = 1'b1;
          redirect_pc_d     = bus.trap_pc_i & PC_MASK;
          redirect_reason_d = IF_TRAP;
        end else if (mispred_acc_s) begin
          state_d           = ST_ISSUE;
          redirect_valid_d  = 1'b1;
          redirect_pc_d     = bus.mispred_pc_i & PC_MASK;
          redirect_reason_d = IF_MISPREDICT;
        end else if (sys_acc_s) begin
          if (bus.sys_flush_i) begin
            state_d       = ST_FLUSH;
            flush_req_d   = 1'b1;
            pend_pc_d     = bus.sys_pc_i & PC_MASK;
            pend_reason_d = bus.sys_reason_i;
          end else begin
            state_d           = ST_ISSUE;
            redirect_valid_d  = 1'b1;
            sys_done_d        = 1'b1;
            redirect_pc_d     = bus.sys_pc_i & PC_MASK;
            redirect_reason_d = bus.sys_reason_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (bus.icache_flush_ack_i) begin
          state_d           = ST_ISSUE;
          redirect_valid_d  = 1'b1;
          sys_done_d        = 1'b1;
          redirect_pc_d     = pend_pc_q;
          redirect_reason_d = pend_reason_q;
        end else begin
          flush_req_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= ST_IDLE;
      redirect_valid_q  <= 1'b0;
      redirect_reason_q <= IF_PREFETCH;
      redirect_pc_q     <= {XLEN{1'b0}};
      sys_done_q        <= 1'b0;
      flush_req_q       <= 1'b0;
      pend_pc_q         <= {XLEN{1'b0}};
      pend_reason_q     <= IF_PREFETCH;
    end else begin
      state_q           <= state_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_reason_q <= redirect_reason_d;
      redirect_pc_q     <= redirect_pc_d;
      sys_done_q        <= sys_done_d;
      flush_req_q       <= flush_req_d;
      pend_pc_q         <= pend_pc_d;
      pend_reason_q     <= pend_reason_d;
    end
  end

endmodule

// File: tb/tb_muntjac_redirect_ctrl.sv
// Bench for muntjac_redirect_ctrl: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the controller.
module tb_muntjac_redirect_ctrl;
  import muntjac_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  muntjac_redirect_ctrl_if #(.XLEN(64)) bus ();

  muntjac_redirect_ctrl #(.XLEN(64)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the controller is either free, flushing for a parked sys
  // request, or showing a redirect pulse (busy for that cycle only).
  logic       e_valid = 1'b0;
  logic       e_done = 1'b0;
  logic       e_flush = 1'b0;
  logic [63:0] e_pc = 64'd0;
  if_reason_e e_reason = IF_PREFETCH;
  logic       m_flushing = 1'b0;
  logic [63:0] m_pc = 64'd0;
  if_reason_e m_reason = IF_PREFETCH;
  logic       prev_valid = 1'b0;
  logic       acc_t, acc_m, acc_s;
  int         flush_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), check readies, advance
  // the model, then check the registered outputs after the edge.
  task automatic drive_cycle(input logic rst,
                             input logic tv, input logic [63:0] tpc,
                             input logic mv, input logic [63:0] mpc,
                             input logic sv, input logic [63:0] spc,
                             input if_reason_e sr, input logic sf,
                             input logic ack);
    logic free;
    rst_i                  = rst;
    bus.trap_valid_i       = tv;
    bus.trap_pc_i          = tpc;
    bus.mispred_valid_i    = mv;
    bus.mispred_pc_i       = mpc;
    bus.sys_valid_i        = sv;
    bus.sys_pc_i           = spc;
    bus.sys_reason_i       = sr;
    bus.sys_flush_i        = sf;
    bus.icache_flush_ack_i = ack;
    #1;
    free = !rst && !m_flushing && !e_valid;
    chk("trap_ready", {63'd0, bus.trap_ready_o}, {63'd0, free});
    chk("mispred_ready", {63'd0, bus.mispred_ready_o}, {63'd0, free && !tv});
    chk("sys_ready", {63'd0, bus.sys_ready_o}, {63'd0, free && !tv && !mv});
    acc_t = tv && free;
    acc_m = mv && free && !tv;
    acc_s = sv && free && !tv && !mv;

    if (rst) begin
      e_valid = 1'b0; e_done = 1'b0; e_flush = 1'b0;
      e_pc = 64'd0; e_reason = IF_PREFETCH; m_flushing = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_done  = 1'b0;
      if (m_flushing) begin
        if (ack) begin
          e_valid = 1'b1; e_done = 1'b1; e_flush = 1'b0;
          e_pc = m_pc; e_reason = m_reason; m_flushing = 1'b0;
        end
      end else if (acc_t) begin
        e_valid = 1'b1; e_pc = tpc & ~64'd1; e_reason = IF_TRAP;
      end else if (acc_m) begin
        e_valid = 1'b1; e_pc = mpc & ~64'd1; e_reason = IF_MISPREDICT;
      end else if (acc_s) begin
        if (sf) begin
          m_flushing = 1'b1; e_flush = 1'b1;
          m_pc = spc & ~64'd1; m_reason = sr;
        end else begin
          e_valid = 1'b1; e_done = 1'b1; e_pc = spc & ~64'd1; e_reason = sr;
        end
      end
    end

    @(posedge clk_i);
    #1;
    chk("redirect_valid", {63'd0, bus.redirect_valid_o}, {63'd0, e_valid});
    chk("sys_done", {63'd0, bus.sys_done_o}, {63'd0, e_done});
    chk("flush_req", {63'd0, bus.icache_flush_req_o}, {63'd0, e_flush});
    chk("redirect_pc", bus.redirect_pc_o, e_pc);
    chk("redirect_reason", 64'(bus.redirect_reason_o), 64'(e_reason));
    chk("no_back_to_back", {63'd0, prev_valid && bus.redirect_valid_o}, 64'd0);
    prev_valid = bus.redirect_valid_o;
    if (bus.icache_flush_req_o) flush_seen++;
  endtask

  task automatic idle_cycle(input logic ack);
    drive_cycle(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, IF_FENCE_I, 1'b0, ack);
  endtask

  logic        r_tv = 1'b0, r_mv = 1'b0, r_sv = 1'b0, r_sf = 1'b0;
  logic [63:0] r_tpc = 64'd0, r_mpc = 64'd0, r_spc = 64'd0;
  if_reason_e  r_sr = IF_FENCE_I;

  initial begin
    // Reset: readies low during the reset cycle, reset values after.
    drive_cycle(1'b1, 1'b1, 64'd4, 1'b1, 64'd8, 1'b1, 64'd12, IF_FENCE_I, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, IF_FENCE_I, 1'b0, 1'b0);
    chk("reset_reason", 64'(bus.redirect_reason_o), 64'(IF_PREFETCH));
    chk("reset_pc", bus.redirect_pc_o, 64'd0);

    // Trap beats a simultaneous mispredict; mispredict accepted two cycles later.
    drive_cycle(1'b0, 1'b1, 64'h8000_0003, 1'b1, 64'h4000, 1'b0, 64'd0, IF_FENCE_I, 1'b0, 1'b0);
    chk("trap_pc_aligned", bus.redirect_pc_o, 64'h8000_0002);
    chk("trap_reason", 64'(bus.redirect_reason_o), 64'(IF_TRAP));
    drive_cycle(1'b0, 1'b0, 64'd0, 1'b1, 64'h4000, 1'b0, 64'd0, IF_FENCE_I, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 64'd0, 1'b1, 64'h4000, 1'b0, 64'd0, IF_FENCE_I, 1'b0, 1'b0);
    chk("mispred_reason", 64'(bus.redirect_reason_o), 64'(IF_MISPREDICT));
    idle_cycle(1'b0);

    // FENCE.I with ack on the fifth flush cycle.
    flush_seen = 0;
    drive_cycle(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 64'h2000, IF_FENCE_I, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle_cycle(1'b0);
    idle_cycle(1'b1);
    chk("fence_flush_cycles", 64'(flush_seen), 64'd5);
    chk("fence_done", {63'd0, bus.sys_done_o}, 64'd1);
    chk("fence_reason", 64'(bus.redirect_reason_o), 64'(IF_FENCE_I));
    idle_cycle(1'b0);

    // FENCE.I with ack already high on the first flush cycle.
    flush_seen = 0;
    drive_cycle(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 64'h2468, IF_FENCE_I, 1'b1, 1'b1);
    idle_cycle(1'b1);
    chk("fence_fast_flush_cycles", 64'(flush_seen), 64'd1);
    chk("fence_fast_valid", {63'd0, bus.redirect_valid_o}, 64'd1);
    idle_cycle(1'b0);

    // SATP change without flush.
    flush_seen = 0;
    drive_cycle(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 64'h1000, IF_SATP_CHANGED, 1'b0, 1'b1);
    chk("satp_pc", bus.redirect_pc_o, 64'h1000);
    chk("satp_reason", 64'(bus.redirect_reason_o), 64'(IF_SATP_CHANGED));
    idle_cycle(1'b1);
    chk("satp_no_flush", 64'(flush_seen), 64'd0);

    // Reset on the third flush cycle aborts the flush.
    drive_cycle(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 64'h3000, IF_FENCE_I, 1'b1, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    drive_cycle(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, IF_FENCE_I, 1'b0, 1'b1);
    chk("abort_flush_low", {63'd0, bus.icache_flush_req_o}, 64'd0);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    chk("abort_sys_ready", {63'd0, bus.sys_ready_o}, 64'd1);

    // Random traffic: requesters hold valid and payload until accepted.
    for (int c = 0; c < 10000; c++) begin
      if (!r_tv && ($urandom_range(0, 3) == 0)) begin
        r_tv = 1'b1; r_tpc = {$urandom, $urandom};
      end
      if (!r_mv && ($urandom_range(0, 3) == 0)) begin
        r_mv = 1'b1; r_mpc = {$urandom, $urandom};
      end
      if (!r_sv && ($urandom_range(0, 3) == 0)) begin
        r_sv = 1'b1; r_spc = {$urandom, $urandom};
        r_sr = ($urandom_range(0, 1) == 0) ? IF_FENCE_I : IF_SATP_CHANGED;
        r_sf = 1'($urandom_range(0, 1));
      end
      drive_cycle(($urandom_range(0, 599) == 0), r_tv, r_tpc, r_mv, r_mpc,
                  r_sv, r_spc, r_sr, r_sf, ($urandom_range(0, 2) == 0));
      if (acc_t) r_tv = 1'b0;
      if (acc_m) r_mv = 1'b0;
      if (acc_s) r_sv = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muntjac_redirect_ctrl.md
MUNTJAC_REDIRECT_CTRL -- requirements
Module: muntjac_redirect_ctrl

Interface
REQ-001 Parameter XLEN, default 64, virtual address width of all PC ports.
REQ-002 Port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port rst_i, input, 1, reset, synchronous, active-high.
REQ-004 Port trap_valid_i / trap_ready_o / trap_pc_i, in/out/in, 1/1/XLEN: trap or interrupt redirect request.
REQ-005 Port mispred_valid_i / mispred_ready_o / mispred_pc_i, in/out/in, 1/1/XLEN: branch-unit mispredict redirect.
REQ-006 Port sys_valid_i / sys_ready_o / sys_pc_i, in/out/in, 1/1/XLEN: system redirect (FENCE.I, SATP write, SFENCE.VMA).
REQ-007 Port sys_reason_i, input, if_reason_e: reason forwarded for the sys request.
REQ-008 Port sys_flush_i, input, 1: sys request requires an icache flush before the redirect.
REQ-009 Port icache_flush_req_o / icache_flush_ack_i, out/in, 1/1: icache flush handshake.
REQ-010 Port redirect_valid_o / redirect_reason_o / redirect_pc_o, out/out/out, 1/if_reason_e/XLEN: redirect to instruction fetcher.
REQ-011 Port sys_done_o, output, 1: one-cycle pulse when a sys request's redirect is issued.

Function
REQ-012 FSM states IDLE, FLUSH, ISSUE; state and all outputs registered.
REQ-013 Ready outputs high only in IDLE; a request is accepted when valid && ready.
REQ-014 Same-cycle priority in IDLE: trap > mispredict > sys; only the winner's ready is high, losers hold.
REQ-015 Trap accepted in cycle N -> redirect_valid_o=1, reason IF_TRAP, pc=trap_pc_i captured, in cycle N+1.
REQ-016 Mispredict accepted in cycle N -> redirect_valid_o=1, reason IF_MISPREDICT in cycle N+1.
REQ-017 Sys with sys_flush_i=0 accepted in cycle N -> redirect with sys_reason_i and sys_done_o=1 in cycle N+1.
REQ-018 Sys with sys_flush_i=1 accepted in cycle N -> FLUSH; icache_flush_req_o=1 from cycle N+1 until the cycle ack is sampled high, inclusive.
REQ-019 FLUSH -> ISSUE on cycle ack sampled high; ack seen in cycle M -> redirect_valid_o and sys_done_o in M+1; flush_req_o low in M+1.
REQ-020 icache_flush_ack_i ignored outside FLUSH.
REQ-021 ISSUE lasts one cycle, then IDLE; redirect_valid_o is a single-cycle pulse, never two consecutive cycles from one request.
REQ-022 Back-to-back: request accepted in the cycle redirect_valid_o pulses is not possible (ready low); next acceptance earliest the cycle after.
REQ-023 IDLE->ISSUE for non-flush requests also passes through ISSUE state; ready low during it.
REQ-024 redirect_pc_o bit 0 forced to 0; higher bits passed unchanged.
REQ-025 Requests arriving during FLUSH/ISSUE held by requester (ready low), not dropped or merged.
REQ-026 redirect_reason_o and redirect_pc_o hold last value when redirect_valid_o=0.

Reset
REQ-027 rst_i high at a rising edge: state IDLE, redirect_valid_o=0, sys_done_o=0, icache_flush_req_o=0, redirect_pc_o=0, redirect_reason_o=IF_PREFETCH.
REQ-028 Reset mid-FLUSH aborts the flush: flush_req_o low next cycle, no redirect issued, pending request lost.
REQ-029 Ready outputs are 0 during the reset cycle and high from the first post-reset cycle.

Structure
REQ-030 if_reason_e values IF_TRAP, IF_MISPREDICT, IF_FENCE_I, IF_SATP_CHANGED live in muntjac_pkg; FSM state enum is local.
REQ-031 Single flat module; no sub-modules.

Verification
REQ-032 Trap pc 0x8000_0003 and mispredict same cycle -> trap accepted, cycle+1 redirect pc 0x8000_0002 IF_TRAP; mispredict accepted 2 cycles later.
REQ-033 FENCE.I sys_flush=1, ack after 5 cycles -> flush_req high exactly 5 cycles, redirect IF_FENCE_I + sys_done one cycle after ack.
REQ-034 FENCE.I with ack already high on first flush_req cycle -> flush_req 1 cycle, redirect next cycle.
REQ-035 SATP sys_flush=0 pc 0x1000 -> redirect 0x1000 IF_SATP_CHANGED next cycle, flush_req never asserted.
REQ-036 rst_i asserted on 3rd FLUSH cycle -> flush_req 0, no redirect_valid_o pulse, readys high after reset.
REQ-037 Random valid traffic 10k cycles -> every accept yields exactly one redirect pulse, never consecutive pulses.
